// File: rtl/int_arbiter_if.sv
// int_arbiter_if: register-window bus between the system bridge and the interrupt arbiter.
interface int_arbiter_if;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    modport master (output addr, we, wdata, input rdata);
    modport slave (input addr, we, wdata, output rdata);
endinterface

// File: rtl/int_arbiter.sv
// int_arbiter: latches IRQ sources as pending bits, masks them and raises one fixed-priority request to CP0.
// Define INT_ARB_EDGE_EN for rising-edge source capture; the default build captures levels.
module int_arbiter #(
    parameter int          N_SRC     = 6,
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F40
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_SRC-1:0] src_i,
    int_arbiter_if.slave     bus,
    input  logic             int_taken,
    input  logic             eret,
    output logic [N_SRC-1:0] hw_int,
    output logic             irq
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SERV = 2'd2} state_e;
    state_e           state_q, state_d;
    logic [N_SRC-1:0] src_q, pend_q, pend_d, mask_q, mask_d;
    logic [N_SRC-1:0] set, ack, req, cur_oh;
    logic [3:0]       cur_q, cur_d, win;
    logic [29:0]      word;
    logic             hit, unused_bits;

    // Window offset in words; wraps for addresses below the base so one compare covers both sides.
    assign word        = bus.addr[31:2] - BASE_ADDR[31:2];
    assign hit         = word < 30'd4;
    assign unused_bits = ^{bus.addr[1:0], bus.wdata};
    assign ack         = (bus.we && hit && word[1:0] == 2'd2) ? bus.wdata[N_SRC-1:0] : '0;
    assign mask_d      = (bus.we && hit && word[1:0] == 2'd1) ? bus.wdata[N_SRC-1:0] : mask_q;
`ifdef INT_ARB_EDGE_EN
    assign set = src_i & ~src_q;
`else
    assign set = src_q;
`endif
    assign pend_d = (pend_q & ~ack) | set;
    assign req    = pend_q & mask_q;
    assign cur_oh = N_SRC'(1) << cur_q;

    always_comb begin
        win = '0;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (req[i]) win = 4'(i);
    end

    assign bus.rdata = !hit              ? 32'd0 :
                       word[1:0] == 2'd0 ? 32'(pend_q) :
                       word[1:0] == 2'd1 ? 32'(mask_q) :
                       word[1:0] == 2'd3 ? {22'd0, state_q, 4'd0, cur_q} : 32'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_q  <= '0;
            pend_q <= '0;
            mask_q <= '0;
            cur_q  <= '0;
        end else begin
            src_q  <= src_i;
            pend_q <= pend_d;
            mask_q <= mask_d;
            cur_q  <= cur_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else state_q <= state_d;
    end

    // The winner is frozen at IDLE->REQ; a REQ is withdrawn when its bit is no longer pending and enabled.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        case (state_q)
            IDLE: if (|req) begin
                state_d = REQ;
                cur_d   = win;
            end
            REQ: state_d = int_taken ? SERV : (|(pend_d & mask_d & cur_oh)) ? REQ : IDLE;
            SERV: state_d = (|(ack & cur_oh) || eret) ? IDLE : SERV;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        irq    = state_q == REQ;
        hw_int = irq ? cur_oh : '0;
    end
endmodule

// File: tb/tb_int_arbiter.sv
// tb_int_arbiter: randomized and directed stimulus scored against a rule-level model of the arbiter.
module tb_int_arbiter;
    localparam int          N    = 6;
    localparam logic [31:0] BASE = 32'h0000_7F40;
    localparam int          ALL  = (1 << N) - 1;

    logic         clk = 0, reset = 1;
    logic [N-1:0] src = '0;
    logic         int_taken = 0, eret = 0;
    logic [N-1:0] hw_int;
    logic         irq;
    bit           rst_nxt = 1;

    int_arbiter_if bus();
    int_arbiter #(.N_SRC(N), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .src_i(src), .bus(bus),
        .int_taken(int_taken), .eret(eret), .hw_int(hw_int), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         irq;
        logic [N-1:0] hw;
        logic [31:0]  rd;
    } exp_t;
    exp_t sb[$];
    event chk;
    int   vectors = 0, miscompares = 0;

    // Model: pending/mask sets, previous source sample, state 0=idle 1=requesting 2=in service.
    int m_pend, m_mask, m_prev, m_st, m_cur;

    function automatic void model_reset();
        m_pend = 0; m_mask = 0; m_prev = 0; m_st = 0; m_cur = 0;
    endfunction

    function automatic int lowest(int v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic int offset_of(logic [31:0] a);
        if (a < BASE || a >= BASE + 32'd16) return -1;
        return int'((a - BASE) >> 2);
    endfunction

    function automatic logic [31:0] reg_read(logic [31:0] a);
        case (offset_of(a))
            0: return 32'(m_pend);
            1: return 32'(m_mask);
            3: return 32'((m_st << 8) | m_cur);
            default: return 32'd0;
        endcase
    endfunction

    function automatic void model_step();
        int off, ack, nmask, npend, set;
        off   = bus.we ? offset_of(bus.addr) : -1;
        ack   = (off == 2) ? int'(bus.wdata) & ALL : 0;
        nmask = (off == 1) ? int'(bus.wdata) & ALL : m_mask;
`ifdef INT_ARB_EDGE_EN
        set = int'(src) & ~m_prev & ALL;
`else
        set = m_prev;
`endif
        npend = (m_pend & ~ack) | set;
        if (m_st == 0) begin
            if ((m_pend & m_mask) != 0) begin
                m_st  = 1;
                m_cur = lowest(m_pend & m_mask);
            end
        end else if (m_st == 1) begin
            if (int_taken) m_st = 2;
            else if (((npend & nmask) >> m_cur & 1) == 0) m_st = 0;
        end else if (((ack >> m_cur) & 1) == 1 || eret) m_st = 0;
        m_pend = npend;
        m_mask = nmask;
        m_prev = int'(src);
    endfunction

    task automatic cyc(input int s, input bit tk, input bit er, input bit w, input logic [31:0] a, input int d);
        exp_t e;
        @(negedge clk);
        reset = rst_nxt;
        if (rst_nxt) model_reset();
        src = N'(s); int_taken = tk; eret = er;
        bus.we = w; bus.addr = a; bus.wdata = 32'(d);
        e.irq = (m_st == 1);
        e.hw  = (m_st == 1) ? N'(1 << m_cur) : '0;
        e.rd  = reg_read(a);
        sb.push_back(e);
        ->chk;
        @(posedge clk);
        if (!reset) model_step();
    endtask

    task automatic rd(input int off, input int n = 1);
        repeat (n) cyc(0, 0, 0, 0, BASE + 32'(off), 0);
    endtask

    task automatic wr(input int off, input int d);
        cyc(0, 0, 0, 1, BASE + 32'(off), d);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(chk);
            #1;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard: output sampled with no expectation queued");
            end else begin
                e = sb.pop_front();
                vectors++;
                if (irq !== e.irq) begin
                    miscompares++;
                    $display("FAIL irq @%0t: got %b want %b", $time, irq, e.irq);
                end
                if (hw_int !== e.hw) begin
                    miscompares++;
                    $display("FAIL hw_int @%0t: got %h want %h", $time, hw_int, e.hw);
                end
                if (bus.rdata !== e.rd) begin
                    miscompares++;
                    $display("FAIL rdata @%0t addr %h: got %h want %h", $time, bus.addr, bus.rdata, e.rd);
                end
            end
        end
    end

    initial begin
        int s, op;
        logic [31:0] a;
        bus.we = 0; bus.addr = BASE; bus.wdata = 0;
        model_reset();
        rd(0); rd(4); rd(8); rd('hC); rd('h10);
        rst_nxt = 0;
        wr(4, 'h3F); cyc('h04, 0, 0, 0, BASE, 0); rd(0); rd('hC, 3);
        cyc(0, 1, 0, 0, BASE + 12, 0); wr(8, 'h04); rd('hC, 2);
        cyc('h12, 0, 0, 0, BASE, 0); rd('hC, 4);
        cyc(0, 1, 0, 0, BASE + 12, 0); wr(8, 'h02); rd('hC, 3);
        cyc(0, 1, 0, 0, BASE + 12, 0); wr(8, 'h10); rd(0, 2);
        wr(4, 0); cyc('h01, 0, 0, 0, BASE, 0); rd(0, 3);
        wr(4, 'h01); rd('hC, 3); wr(8, 'h01); rd('hC, 2);
        wr(4, 'h3F); cyc('h08, 0, 0, 0, BASE, 0); rd('hC, 3);
        wr(4, 0); rd(0); rd('hC);
        wr(4, 'h3F); rd('hC, 2); cyc(0, 1, 0, 0, BASE + 12, 0); rd('hC);
        cyc(0, 0, 1, 0, BASE + 12, 0); rd('hC, 3);
        cyc(0, 1, 0, 0, BASE + 12, 0); cyc('h08, 0, 0, 1, BASE + 8, 'h08); rd(0, 3);
        rst_nxt = 1; rd('h10); rd(0); rd(4);
        rst_nxt = 0; cyc(0, 1, 1, 0, BASE + 12, 0); rd('hC, 2);
        for (int c = 0; c < 3000; c++) begin
            s  = ($urandom_range(0, 5) == 0) ? int'($urandom) & ALL : 0;
            op = $urandom_range(0, 9);
            a  = BASE - 32'd8 + 32'($urandom_range(0, 31));
            rst_nxt = ($urandom_range(0, 399) == 0);
            case (op)
                0, 1: cyc(s, $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0, 1, BASE + 4, int'($urandom));
                2: cyc(s, $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0, 1, BASE + 8, int'($urandom));
                3: cyc(s, 0, 0, 1, BASE + 8, 1 << m_cur);
                4: cyc(s, $urandom_range(0, 4) == 0, 0, 1, a, int'($urandom));
                default: cyc(s, $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0, 0, a, 0);
            endcase
        end
        rst_nxt = 0;
        rd(0);
        @(negedge clk);
        #2;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
